// File: rtl/fmap_read_sched_pkg.sv
// Shared definitions for the feature-map read scheduler: controller states and
// default scratch-pad / size-field widths.
package fmap_read_sched_pkg;

  localparam int ADDRESSWIDTH_F_PAD = 10;
  localparam int SIZE_PARA_BITS     = 10;

  typedef enum logic [2:0] {
    IDLE,
    LREQ,
    STREAM,
    CWAIT,
    FIN
  } state_t;

endpackage

// File: rtl/fmap_addr_rep_cnt.sv
// Scratch-pad read address / repeat counter: each address is held for weight_num
// enabled cycles; 'last' flags the enabled cycle that consumes the final column address.
module fmap_addr_rep_cnt #(
  parameter int ADDR_W = 10,
  parameter int SIZE_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [SIZE_W-1:0] load_addr,
  input  logic [SIZE_W-1:0] load_end,
  input  logic              en,
  input  logic [SIZE_W-1:0] weight_num,
  output logic [ADDR_W-1:0] addr,
  output logic [SIZE_W-1:0] col_end,
  output logic              last
);

  localparam int CW = ((ADDR_W > SIZE_W) ? ADDR_W : SIZE_W) + 1;

  logic [SIZE_W-1:0] rep_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [SIZE_W-1:0] col_end_reg;
  logic              wrap;
  logic [CW-1:0]     addr_inc;

  // weight_num is never 0 here; the caller maps 0 to 1 when latching it
  assign wrap     = ({1'b0, rep_reg} + (SIZE_W+1)'(1)) == {1'b0, weight_num};
  assign addr_inc = CW'(addr_reg) + CW'(1);
  assign last     = en & wrap & (addr_inc == CW'(col_end_reg));
  assign addr     = addr_reg;
  assign col_end  = col_end_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_reg     <= '0;
      addr_reg    <= '0;
      col_end_reg <= '0;
    end else if (load) begin
      rep_reg     <= '0;
      addr_reg    <= ADDR_W'(load_addr);
      col_end_reg <= load_end;
    end else if (en) begin
      if (wrap) begin
        rep_reg  <= '0;
        addr_reg <= addr_inc[ADDR_W-1:0];
      end else begin
        rep_reg <= rep_reg + SIZE_W'(1);
      end
    end
  end

endmodule

// File: rtl/fmap_read_sched.sv
// Feature-map read scheduler: sequences load_fmap loads and streams scratch-pad reads
// to the PE array. Define FMAP_SCHED_PERF_EN to add the stall_cnt performance counter.
module fmap_read_sched
  import fmap_read_sched_pkg::*;
#(
  parameter int ADDR_W = ADDRESSWIDTH_F_PAD,
  parameter int SIZE_W = SIZE_PARA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_full,
  input  logic [SIZE_W-1:0] pixel_num,
  input  logic [SIZE_W-1:0] col_len,
  input  logic [SIZE_W-1:0] weight_num,
  input  logic              pe_ready,
  input  logic              fmap_ready,
  input  logic              pad_data_ready,
  input  logic              pad_full,
  output logic              load_start,
  output logic              load_full_column,
  output logic [ADDR_W-1:0] raddr,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
`ifdef FMAP_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  state_t            state_reg, state_next;
  logic              mode_reg;
  logic [SIZE_W-1:0] pix_reg, col_len_reg, wnum_reg, base_reg;
  logic              col_loaded_reg;
  logic              accept, issue, last_issue;
  logic [SIZE_W:0]   col_sum;
  logic [SIZE_W-1:0] col_end_calc, col_end;
  logic [ADDR_W-1:0] addr;

  assign accept  = (state_reg == IDLE) & start;
  assign issue   = (state_reg == STREAM) & pe_ready & pad_data_ready & ~pad_full;
  assign col_sum = {1'b0, base_reg} + {1'b0, col_len_reg};

  // Column end is clipped to pixel_num; col_len==0 collapses to one full-width column
  always_comb begin
    col_end_calc = pix_reg;
    if (!mode_reg && (col_len_reg != '0) && (col_sum < {1'b0, pix_reg}))
      col_end_calc = col_sum[SIZE_W-1:0];
  end

  fmap_addr_rep_cnt #(
    .ADDR_W(ADDR_W),
    .SIZE_W(SIZE_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (state_reg == LREQ),
    .load_addr (base_reg),
    .load_end  (col_end_calc),
    .en        (issue),
    .weight_num(wnum_reg),
    .addr      (addr),
    .col_end   (col_end),
    .last      (last_issue)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (pixel_num == '0) ? FIN : LREQ;
      LREQ:    state_next = STREAM;
      STREAM:  if (last_issue) state_next = CWAIT;
      CWAIT:   if (col_loaded_reg) state_next = (col_end == pix_reg) ? FIN : LREQ;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_start       = (state_reg == LREQ);
    load_full_column = (state_reg == LREQ) & mode_reg;
    busy             = (state_reg != IDLE);
    done             = (state_reg == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg       <= 1'b0;
      pix_reg        <= '0;
      col_len_reg    <= '0;
      wnum_reg       <= '0;
      base_reg       <= '0;
      col_loaded_reg <= 1'b0;
      raddr          <= '0;
      rd_valid       <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (issue) raddr <= addr;
      if (accept) begin
        mode_reg    <= mode_full;
        pix_reg     <= pixel_num;
        col_len_reg <= col_len;
        wnum_reg    <= (weight_num == '0) ? SIZE_W'(1) : weight_num;
        base_reg    <= '0;
      end
      // Load-done pulses may land while still streaming, so they are held until CWAIT
      if (state_reg == LREQ)
        col_loaded_reg <= 1'b0;
      else if ((state_reg != IDLE) && fmap_ready)
        col_loaded_reg <= 1'b1;
      if ((state_reg == CWAIT) && col_loaded_reg && (col_end != pix_reg))
        base_reg <= col_end;
    end
  end

`ifdef FMAP_SCHED_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_reg <= '0;
    else if (accept)
      stall_cnt_reg <= '0;
    else if ((state_reg == STREAM) && pe_ready && !issue && (stall_cnt_reg != '1))
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fmap_read_sched.sv
// Self-checking bench for fmap_read_sched: emulates load_fmap and pad/PE flow control,
// and compares the read stream against a per-job expected address list.
module tb_fmap_read_sched;

  localparam int ADDR_W = 10;
  localparam int SIZE_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode_full = 1'b0;
  logic [SIZE_W-1:0] pixel_num = '0;
  logic [SIZE_W-1:0] col_len = '0;
  logic [SIZE_W-1:0] weight_num = '0;
  logic pe_ready = 1'b0;
  logic fmap_ready = 1'b0;
  logic pad_data_ready = 1'b0;
  logic pad_full = 1'b0;
  logic load_start, load_full_column, rd_valid, busy, done;
  logic [ADDR_W-1:0] raddr;
`ifdef FMAP_SCHED_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // control set by the main sequence (only at posedge+3), read by helper processes
  int stim_mode = 0;
  bit force_full = 1'b0;
  bit exp_mode = 1'b0;

  // written only by helper processes, read by the main sequence
  int got_q[$];
  int load_cnt = 0, overlap_cnt = 0, lfc_bad = 0, done_cnt = 0, busy_bad = 0;
  int pending = 0, cd = 0;
  bit tog = 1'b0;
  logic [ADDR_W-1:0] last_raddr = '0;

  // per-job expectations
  int exp_q[$];
  int exp_loads;
  int b_got, b_load, b_ovl, b_lfc, b_done, b_bb;

  always #5 clk = ~clk;

  fmap_read_sched #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .mode_full       (mode_full),
    .pixel_num       (pixel_num),
    .col_len         (col_len),
    .weight_num      (weight_num),
    .pe_ready        (pe_ready),
    .fmap_ready      (fmap_ready),
    .pad_data_ready  (pad_data_ready),
    .pad_full        (pad_full),
    .load_start      (load_start),
    .load_full_column(load_full_column),
    .raddr           (raddr),
    .rd_valid        (rd_valid),
    .busy            (busy),
    .done            (done)
`ifdef FMAP_SCHED_PERF_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pad / PE flow-control patterns
  always @(negedge clk) begin
    case (stim_mode)
      0: begin pe_ready = 1'b1; pad_data_ready = 1'b1; pad_full = 1'b0; end
      1: begin
        pe_ready       = ($urandom_range(0, 3) != 0);
        pad_data_ready = ($urandom_range(0, 4) != 0);
        pad_full       = ($urandom_range(0, 6) == 0);
      end
      2: begin tog = ~tog; pe_ready = tog; pad_data_ready = 1'b1; pad_full = 1'b0; end
      default: begin pe_ready = 1'b1; pad_data_ready = 1'b1; pad_full = force_full; end
    endcase
  end

  // load_fmap stand-in: answers each load_start with one fmap_ready pulse 1..6 cycles later
  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
      fmap_ready = 1'b0;
    end else begin
      fmap_ready = 1'b0;
      if (pending != 0) begin
        cd--;
        if (cd == 0) begin
          fmap_ready = 1'b1;
          pending = 0;
        end
      end
      if (load_start) begin
        load_cnt++;
        if (pending != 0) overlap_cnt++;
        if (load_full_column !== exp_mode) lfc_bad++;
        pending = 1;
        cd = $urandom_range(1, 6);
      end
    end
  end

  // output monitor: inputs seen here are the ones the DUT just sampled
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (rd_valid) got_q.push_back(int'(raddr));
      if (!(pe_ready && pad_data_ready && !pad_full))
        check("rd_valid_without_issue", rd_valid, 1'b0);
      if (!rd_valid) check("raddr_hold", raddr, last_raddr);
      if (done) begin
        done_cnt++;
        if (busy !== 1'b1) busy_bad++;
      end
    end
    last_raddr = raddr;
  end

  task automatic start_job(input bit full, input int n, input int cl, input int wn,
                           input int smode, input bit poke);
    int wn_eff, cl_eff;
    @(posedge clk); #3;
    stim_mode = smode;
    exp_mode  = full;
    wn_eff = (wn == 0) ? 1 : wn;
    cl_eff = (full || cl == 0) ? n : cl;
    exp_q.delete();
    for (int p = 0; p < n; p++)
      for (int r = 0; r < wn_eff; r++) exp_q.push_back(p);
    exp_loads = (n == 0) ? 0 : (n + cl_eff - 1) / cl_eff;
    b_got = got_q.size(); b_load = load_cnt; b_ovl = overlap_cnt;
    b_lfc = lfc_bad; b_done = done_cnt; b_bb = busy_bad;
    $display("job: full=%0d pixels=%0d col_len=%0d weight_num=%0d flow=%0d", full, n, cl, wn, smode);
    @(negedge clk);
    mode_full = full; pixel_num = SIZE_W'(n); col_len = SIZE_W'(cl); weight_num = SIZE_W'(wn);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1; pixel_num = SIZE_W'(3); mode_full = ~full;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic finish_job();
    int k = 0;
    int bad = -1;
    while (done_cnt == b_done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("job_done_in_time", (k < 4000), 1'b1);
    @(posedge clk); #2;
    check("busy_after_done", busy, 1'b0);
    @(negedge clk);
    check("read_count", got_q.size() - b_got, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (b_got + i < got_q.size() && bad < 0 && got_q[b_got + i] != exp_q[i]) bad = i;
    check("first_wrong_addr_index", bad, -1);
    check("load_start_count", load_cnt - b_load, exp_loads);
    check("load_before_fmap_ready", overlap_cnt - b_ovl, 0);
    check("load_full_column_value", lfc_bad - b_lfc, 0);
    check("done_pulses", done_cnt - b_done, 1);
    check("busy_low_at_done", busy_bad - b_bb, 0);
  endtask

  task automatic wait_reads(input int cnt);
    int k = 0;
    while (got_q.size() - b_got < cnt && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reads_reached", (k < 2000), 1'b1);
  endtask

  initial begin
    logic [ADDR_W-1:0] frozen;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    check("rst_load_start", load_start, 1'b0);
    check("rst_raddr", raddr, '0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    start_job(1'b1, 8, 0, 1, 0, 1'b0);
    finish_job();
    start_job(1'b0, 10, 4, 2, 0, 1'b0);
    finish_job();

    // pad_full held for five cycles in the middle of a stream
    start_job(1'b1, 12, 0, 1, 3, 1'b0);
    wait_reads(4);
    @(posedge clk); #3;
    frozen = raddr;
    force_full = 1'b1;
    repeat (5) begin
      @(posedge clk); #2;
      check("stall_rd_valid", rd_valid, 1'b0);
      check("stall_raddr", raddr, frozen);
    end
    #1 force_full = 1'b0;
    finish_job();
`ifdef FMAP_SCHED_PERF_EN
    check("stall_cnt", stall_cnt, 32'd5);
`endif

    start_job(1'b1, 4, 0, 0, 2, 1'b0);
    finish_job();

    // zero-pixel job: straight to FIN
    @(posedge clk); #3;
    b_load = load_cnt; b_done = done_cnt;
    @(negedge clk);
    pixel_num = '0; start = 1'b1;
    @(posedge clk); #2;
    check("zero_busy", busy, 1'b1);
    check("zero_done", done, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #2;
    check("zero_busy_end", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("zero_no_load", load_cnt - b_load, 0);
    check("zero_done_pulses", done_cnt - b_done, 1);

    // reset in the middle of a stream, then a fresh job
    start_job(1'b0, 20, 5, 1, 0, 1'b0);
    wait_reads(5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    check("midrst_load_start", load_start, 1'b0);
    check("midrst_load_full_column", load_full_column, 1'b0);
    check("midrst_raddr", raddr, '0);
    check("midrst_rd_valid", rd_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_job(1'b1, 6, 0, 3, 1, 1'b0);
    finish_job();

    for (int i = 0; i < 8; i++) begin
      bit full;
      int n, cl, wn;
      full = 1'($urandom_range(0, 1));
      n    = $urandom_range(1, 24);
      cl   = $urandom_range(0, 7);
      wn   = $urandom_range(0, 3);
      start_job(full, n, cl, wn, 1, (n >= 4) && (i % 2 == 1));
      finish_job();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fmap_read_sched.md
Name: fmap_read_sched

Overview:
- Controller that sequences the feature-map load/scratch-pad block (load_fmap) and generates its scratch-pad read stream toward the PE array.
- Issues load start pulses, in either full-column or column-by-column mode.
- Issues read addresses, repeating each pixel weight_num times for weight reuse.
- Stalls on the pad_full / pad_data_ready flags and on PE backpressure. Pulses done when the last read datum reaches the PE.

Parameters:
- ADDR_W, 10, scratch-pad address width; equals `ADDRESSWIDTH_F_PAD.
- SIZE_W, 10, width of size fields; equals `Size_para_bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle job start; ignored while busy
- mode_full  in  1  1 = full-column load, 0 = column-by-column; sampled at start
- pixel_num  in  SIZE_W  total pixels; sampled at start
- col_len  in  SIZE_W  pixels per column (column mode); sampled at start
- weight_num  in  SIZE_W  reads per pixel; sampled at start; 0 treated as 1
- pe_ready  in  1  PE accepts data this cycle
- fmap_ready  in  1  load block finished the current load (pulse)
- pad_data_ready  in  1  pad holds readable data
- pad_full  in  1  reader too close to writer; stall
- load_start  out  1  one-cycle pulse to load block
- load_full_column  out  1  mode to load block; valid with load_start
- raddr  out  ADDR_W  scratch-pad read address
- rd_valid  out  1  fmap_out valid this cycle (raddr delayed 1)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job complete

Behaviour:
- Reset values: every output is 0; state is IDLE; all counters are 0.
- Issue condition: issue = (state==STREAM) & pe_ready & pad_data_ready & ~pad_full.
- On issue:
  - raddr takes the current address.
  - rd_valid goes high the next cycle, matching the 1-cycle registered pad read.
  - rep increments. When rep == weight_num-1, rep clears and addr increments.
- FSM states and transitions:
  - IDLE: on start, latch the size fields, set busy=1, base=0, then go to LREQ. If pixel_num==0, go straight to FIN instead.
  - LREQ:
    - Assert load_start=1 for 1 cycle, with load_full_column=mode_full.
    - Set addr=base and col_end:
      - full mode: pixel_num;
      - column mode: min(base+col_len, pixel_num).
    - Clear col_loaded, then go to STREAM.
  - STREAM:
    - Issue reads as above.
    - When addr reaches col_end after the last repetition, go to CWAIT.
    - fmap_ready sets col_loaded in any state except IDLE.
  - CWAIT:
    - Wait for col_loaded; load_fmap only accepts start in its INITIAL state.
    - Then, if col_end==pixel_num, go to FIN. Otherwise set base=col_end and go to LREQ.
  - FIN: wait 1 cycle so the final rd_valid is emitted, then pulse done, set busy=0, go to IDLE.
- Width rules:
  - The base+col_len compare uses SIZE_W+1 bits; there is no wrap.
  - Addresses beyond 2^ADDR_W-1 are a configuration error and undefined.
- col_len==0 in column mode: treated as col_len=pixel_num, i.e. a single column.
- Simultaneous events:
  - A fmap_ready pulse that arrives in the same cycle as the last issue is still captured.
  - start during busy is ignored; it is neither queued nor latched.
- Stall: while issue is low, raddr holds and rd_valid=0. The cycle count of a stall is unbounded.
- Reset mid-job: immediate return to IDLE with all outputs 0. The load block is reset by the same rst.

Optional Feature:
- Macro: FMAP_SCHED_PERF_EN.
- Defined:
  - Adds output stall_cnt [31:0], counting STREAM cycles where pe_ready=1 but issue=0 (pad-side stalls).
  - The count clears on start and saturates at all-ones.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include: state encodings (IDLE, LREQ, STREAM, CWAIT, FIN), `ADDRESSWIDTH_F_PAD and `Size_para_bits.
- One natural sub-module, fmap_addr_rep_cnt: address/repeat counter with issue enable, weight_num wrap and col_end compare.

Test Plan:
- Full mode, pixel_num=8, weight_num=1, pads always ready: 1 load_start with load_full_column=1; raddr 0..7 on 8 consecutive cycles; rd_valid lags by 1 cycle; done after fmap_ready + FIN.
- Column mode, pixel_num=10, col_len=4, weight_num=2: 3 load_start pulses; addresses 0,0,1,1..9,9; the last column is 8..9 (truncated); no second start before fmap_ready.
- pad_full held high 5 cycles mid-stream with pe_ready=1: raddr frozen, rd_valid=0 for 5 cycles, no address skipped; with FMAP_SCHED_PERF_EN, stall_cnt=5.
- pe_ready toggling 1/0 with weight_num=0: each address 0..3 issued exactly once; rd_valid only in cycles following issue.
- pixel_num=0: busy and done both high 1 cycle after start; no load_start.
- rst asserted mid-STREAM, then a new start: all outputs 0 during reset; the new job begins at raddr=0 with a fresh load_start.
